pwm_capture: RTL and testbench
==============================

Name: pwm_capture

Overview:
- Receive-side counterpart of the PWM generator. Measures an incoming PWM waveform in clk cycles and reports high time and period.
- Sits on a dedicated input pin. Result is read through a selectable output bus.
- Used for loopback self-test of the generator and for decoding external PWM sources.

Parameters:
CNT_W, 12, width of the measurement counters and result registers (matches the generator's 12-bit setting width)
SYNC_STAGES, 2, number of flops in the pwm_in synchronizer (minimum 2)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
pwm_in  input  1  asynchronous PWM input
rd_sel  input  1  0 = data_out shows high time, 1 = data_out shows period
clr  input  1  synchronous single-cycle pulse; clears valid and overflow
data_out  output  CNT_W  selected result register (combinational mux of two registers)
valid  output  1  sticky flag: at least one complete measurement since the last clr/reset
overflow  output  1  sticky flag: a counter timeout has occurred since the last clr/reset

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: synchronizer flops 0, FSM IDLE, counter 0, high_reg 0, period_reg 0, valid 0, overflow 0, so data_out = 0.
- Input path: pwm_in passes through SYNC_STAGES flops to give s. Edge detection compares s with s_d (s delayed one cycle).
  - rise = s & ~s_d
  - fall = ~s & s_d
- FSM states:
  - IDLE: wait for rise. On rise, cnt <= 0 and go to HIGH.
  - HIGH: cnt += 1 each cycle. On fall, high_lat <= cnt and go to LOW.
  - LOW: cnt += 1 each cycle. On rise:
    - period_reg <= cnt, high_reg <= high_lat, valid <= 1
    - cnt <= 0, stay measuring and go to HIGH (back-to-back periods are measured continuously)
- Counting rule: input high H cycles and low L cycles gives high_reg = H and period_reg = H+L.
- Latency: valid and the registers update on the clock edge SYNC_STAGES+1 edges after the edge that first samples the rising pwm_in.
- Timeout: if cnt reaches 2^CNT_W-1 in HIGH or LOW:
  - overflow <= 1, go to IDLE, cnt <= 0
  - high_reg and period_reg retain their last values
  - this covers a stuck-at input (0% or 100% duty) and periods too long to measure
- Minimum measurable: H >= 1, L >= 1. A 1-cycle pulse is measured as H = 1.
- clr: valid <= 0 and overflow <= 0. Registers are not cleared. FSM is unaffected.
- Simultaneous events:
  - clr in the same cycle as a completed measurement: valid = 1 (set wins), and registers update.
  - clr in the same cycle as a timeout: overflow = 1 (set wins).
- rd_sel only switches the combinational data_out mux. It has no state effect.
- Reset mid-measurement: immediate asynchronous return to reset values. The first measurement after reset requires a full rise-fall-rise sequence.

Optional Feature:
- Macro: PWM_CAPTURE_GLITCH_FILTER_EN
- Defined:
  - A filter stage follows the synchronizer. The filtered level f changes only after s has held the new value for 3 consecutive cycles.
  - Edge detection uses f.
  - Pulses or gaps of 1-2 cycles are ignored and merged into the surrounding phase.
  - Latency increases by 2 cycles. H and L measured on a clean signal are unchanged, because both edges are delayed equally.
  - Minimum measurable H and L become 3.
- Undefined: no filter. Edge detection uses s directly, as described above.

Test Plan:
- Reset, then pwm_in high 5 / low 11 for 3 periods:
  - valid rises after the second rising edge
  - rd_sel=0 gives data_out=5; rd_sel=1 gives data_out=16; overflow=0
- Duty change mid-stream from 5/11 to 12/4: the next completed period reports high=12, period=16 with no spurious intermediate value.
- pwm_in held at 1 after one rise (CNT_W=12): overflow=1 exactly 4095 cycles after the HIGH state is entered; registers keep their previous values; FSM returns to IDLE.
- Pulse clr in the same cycle a measurement completes: valid stays 1. A clr pulse alone: valid=0 and overflow=0, data_out unchanged.
- Deassert rst_n during LOW: all outputs 0 immediately. After release, no valid until a full rise-fall-rise sequence.
- With PWM_CAPTURE_GLITCH_FILTER_EN, waveform 8/8 with a 1-cycle low glitch inside the high phase: reports high=8, period=16. Without the macro, the same waveform reports a short high time.

Source files
------------

// File: rtl/pwm_capture.sv
// pwm_capture: measures the high time and period of an asynchronous PWM input in clk cycles.
// Define PWM_CAPTURE_GLITCH_FILTER_EN to insert a 3-cycle glitch filter after the synchronizer.
module pwm_capture #(
  parameter int CNT_W       = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  input  logic             rd_sel,
  input  logic             clr,
  output logic [CNT_W-1:0] data_out,
  output logic             valid,
  output logic             overflow
);

  localparam logic [1:0]       ST_IDLE  = 2'd0;
  localparam logic [1:0]       ST_HIGH  = 2'd1;
  localparam logic [1:0]       ST_LOW   = 2'd2;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   s_d_q;
  logic                   lvl;
  logic                   lvl_prev;
  logic                   rise_q;
  logic                   fall_q;
  logic [1:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       cnt_inc;
  logic [CNT_W-1:0]       high_lat_q, high_lat_d;
  logic [CNT_W-1:0]       high_q, high_d;
  logic [CNT_W-1:0]       period_q, period_d;
  logic                   valid_q, valid_d;
  logic                   ovf_q, ovf_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  logic s_d2_q;
  logic filt_q;

  // The filtered level only follows s once three consecutive samples agree.
  assign lvl      = ((s == s_d_q) && (s_d_q == s_d2_q)) ? s : filt_q;
  assign lvl_prev = filt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_d2_q <= 1'b0;
      filt_q <= 1'b0;
    end else begin
      s_d2_q <= s_d_q;
      filt_q <= lvl;
    end
  end
`else
  assign lvl      = s;
  assign lvl_prev = s_d_q;
`endif

  // Edge pulses are registered so the FSM sees clean single-cycle events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_d_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s_d_q  <= s;
      rise_q <= lvl & ~lvl_prev;
      fall_q <= ~lvl & lvl_prev;
    end
  end

  assign cnt_inc = cnt_q + CNT_ONE;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    high_lat_d = high_lat_q;
    high_d     = high_q;
    period_d   = period_q;
    valid_d    = clr ? 1'b0 : valid_q;
    ovf_d      = clr ? 1'b0 : ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (rise_q) begin
          cnt_d   = CNT_ZERO;
          state_d = ST_HIGH;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end
      ST_HIGH: begin
        if (cnt_inc == CNT_MAX) begin
          ovf_d   = 1'b1;
          cnt_d   = CNT_ZERO;
          state_d = ST_IDLE;
        end else if (fall_q) begin
          high_lat_d = cnt_inc;
          cnt_d      = cnt_inc;
          state_d    = ST_LOW;
        end else begin
          cnt_d      = cnt_inc;
        end
      end
      ST_LOW: begin
        // Timeout wins over a coincident rise, so the longest reported period is CNT_MAX-1.
        if (cnt_inc == CNT_MAX) begin
          ovf_d   = 1'b1;
          cnt_d   = CNT_ZERO;
          state_d = ST_IDLE;
        end else if (rise_q) begin
          period_d = cnt_inc;
          high_d   = high_lat_q;
          valid_d  = 1'b1;
          cnt_d    = CNT_ZERO;
          state_d  = ST_HIGH;
        end else begin
          cnt_d    = cnt_inc;
        end
      end
      default: begin
        cnt_d   = CNT_ZERO;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= CNT_ZERO;
      high_lat_q <= CNT_ZERO;
      high_q     <= CNT_ZERO;
      period_q   <= CNT_ZERO;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      high_lat_q <= high_lat_d;
      high_q     <= high_d;
      period_q   <= period_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
    end
  end

  assign data_out = rd_sel ? period_q : high_q;
  assign valid    = valid_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: timestamp-based reference model compared every cycle, plus literal checks.
module tb_pwm_capture;

  localparam int CNT_W = 12;
  localparam int SYNC  = 2;
  localparam int MAXC  = (1 << CNT_W) - 1;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam bit FILT = 1'b1;
  localparam int LAT  = SYNC + 3;
`else
  localparam bit FILT = 1'b0;
  localparam int LAT  = SYNC + 1;
`endif

  logic             clk;
  logic             rst_n;
  logic             pwm_in;
  logic             rd_sel;
  logic             clr;
  logic [CNT_W-1:0] data_out;
  logic             valid;
  logic             overflow;

  int checks = 0;
  int errors = 0;

  pwm_capture #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pwm_in   (pwm_in),
    .rd_sel   (rd_sel),
    .clr      (clr),
    .data_out (data_out),
    .valid    (valid),
    .overflow (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pwm_in history -> (optionally filtered) level delayed by the pipeline,
  // then measurements as differences of rise/fall timestamps.
  bit ph [3];
  bit gh [SYNC+3];
  bit m_meas, m_fell, m_valid, m_ovf;
  int m_n, m_trise, m_tfall, m_high, m_period;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) ph[i] = 1'b0;
    for (int i = 0; i < SYNC + 3; i++) gh[i] = 1'b0;
    m_meas = 1'b0; m_fell = 1'b0; m_valid = 1'b0; m_ovf = 1'b0;
    m_n = 0; m_trise = 0; m_tfall = 0; m_high = 0; m_period = 0;
  endtask

  task automatic model_step();
    bit g, xr, xp, set_v, set_o;
    set_v = 1'b0;
    set_o = 1'b0;
    m_n++;
    ph[2] = ph[1];
    ph[1] = ph[0];
    ph[0] = pwm_in;
    if (!FILT) g = ph[0];
    else if ((ph[0] == ph[1]) && (ph[1] == ph[2])) g = ph[0];
    else g = gh[0];
    for (int i = SYNC + 2; i > 0; i--) gh[i] = gh[i-1];
    gh[0] = g;
    xr = gh[SYNC+1];
    xp = gh[SYNC+2];
    if (m_meas) begin
      if (m_n - m_trise == MAXC) begin
        set_o  = 1'b1;
        m_meas = 1'b0;
      end else if (xr && !xp) begin
        if (m_fell) begin
          m_high   = m_tfall - m_trise;
          m_period = m_n - m_trise;
          set_v    = 1'b1;
        end
        m_trise = m_n;
        m_fell  = 1'b0;
      end else if (!xr && xp) begin
        m_fell  = 1'b1;
        m_tfall = m_n;
      end
    end else if (xr && !xp) begin
      m_meas  = 1'b1;
      m_trise = m_n;
      m_fell  = 1'b0;
    end
    m_valid = set_v ? 1'b1 : (clr ? 1'b0 : m_valid);
    m_ovf   = set_o ? 1'b1 : (clr ? 1'b0 : m_ovf);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    int e_d, e_v, e_o;
    forever begin
      @(negedge clk);
      e_d = rst_n ? (rd_sel ? m_period : m_high) : 0;
      e_v = rst_n ? int'(m_valid) : 0;
      e_o = rst_n ? int'(m_ovf) : 0;
      chk("cmp_data_out", int'(data_out), e_d);
      chk("cmp_valid", int'(valid), e_v);
      chk("cmp_overflow", int'(overflow), e_o);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int h, input int l);
    pwm_in = 1'b1;
    repeat (h) tick();
    pwm_in = 1'b0;
    repeat (l) tick();
  endtask

  initial begin
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    rd_sel = 1'b0;
    clr    = 1'b0;
    repeat (3) tick();
    chk("reset_data_out", int'(data_out), 0);
    chk("reset_valid", int'(valid), 0);
    chk("reset_overflow", int'(overflow), 0);
    rst_n = 1'b1;
    repeat (10) tick();

    // 5/11 stream
    pulse(5, 11);
    chk("first_period_no_valid", int'(valid), 0);
    pulse(5, 11);
    chk("second_rise_valid", int'(valid), 1);
    chk("high_5", int'(data_out), 5);
    rd_sel = 1'b1;
    #1;
    chk("period_16", int'(data_out), 16);
    chk("no_overflow", int'(overflow), 0);
    pulse(5, 11);

    // duty change to 12/4
    pulse(12, 4);
    pulse(12, 4);
    chk("dc_period_16", int'(data_out), 16);
    rd_sel = 1'b0;
    #1;
    chk("dc_high_12", int'(data_out), 12);

    // clr coinciding with a completed measurement
    pwm_in = 1'b1;
    repeat (LAT) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_set_wins_valid", int'(valid), 1);
    chk("clr_set_wins_data", int'(data_out), 12);
    repeat (8 - LAT - 1) tick();
    pwm_in = 1'b0;
    repeat (4) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_alone_valid", int'(valid), 0);
    chk("clr_alone_overflow", int'(overflow), 0);
    chk("clr_alone_data", int'(data_out), 12);
    repeat (3) tick();

    // stuck high: timeout 4095 cycles after HIGH is entered
    pwm_in = 1'b1;
    repeat (LAT + MAXC) tick();
    chk("timeout_not_early", int'(overflow), 0);
    tick();
    chk("timeout_overflow", int'(overflow), 1);
    chk("timeout_keep_high", int'(data_out), 8);
    rd_sel = 1'b1;
    #1;
    chk("timeout_keep_period", int'(data_out), 16);

    // FSM back in IDLE: the next rise only starts a measurement
    clr = 1'b1;
    tick();
    clr = 1'b0;
    pwm_in = 1'b0;
    repeat (6) tick();
    pulse(6, 6);
    chk("idle_after_timeout_valid", int'(valid), 0);
    chk("idle_after_timeout_ovf", int'(overflow), 0);
    pwm_in = 1'b1;
    repeat (LAT + 1) tick();
    chk("after_idle_valid", int'(valid), 1);
    chk("after_idle_period", int'(data_out), 12);

    // asynchronous reset while in LOW
    pwm_in = 1'b0;
    repeat (LAT + 3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_data_out", int'(data_out), 0);
    chk("async_rst_valid", int'(valid), 0);
    chk("async_rst_overflow", int'(overflow), 0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    pulse(4, 4);
    chk("post_rst_no_valid", int'(valid), 0);
    pwm_in = 1'b1;
    repeat (LAT + 1) tick();
    chk("post_rst_valid", int'(valid), 1);
    chk("post_rst_period", int'(data_out), 8);
    rd_sel = 1'b0;
    #1;
    chk("post_rst_high", int'(data_out), 4);

    // 8/8 waveform with a one-cycle low glitch inside the high phase
    pwm_in = 1'b0;
    repeat (8) tick();
    for (int k = 0; k < 2; k++) begin
      pulse(3, 1);
      pulse(4, 8);
    end
    pwm_in = 1'b1;
    repeat (LAT + 1) tick();
    chk("glitch_high", int'(data_out), FILT ? 8 : 4);
    rd_sel = 1'b1;
    #1;
    chk("glitch_period", int'(data_out), FILT ? 16 : 12);
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
